// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and loads the IF/ID register. Supports stall, redirect/flush and halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 36,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        halted_o,
    output logic [31:0] fetch_count_o
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    state_t      state_q;
    logic [31:0] pc_q, if_pc_q, if_instr_q, cnt_q;
    logic        if_valid_q;
    logic        wrap_q;
    logic        legal;
    logic [32:0] pc_inc;

    // wrap_q marks a PC that carried out of 32 bits; it stays illegal until redirected.
    assign legal  = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC) && !wrap_q;
    assign pc_inc = {1'b0, pc_q} + 33'd4;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            wrap_q     <= 1'b0;
            if_pc_q    <= 32'h0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
            cnt_q      <= 32'h0;
        end else begin
            case (state_q)
                BOOT: begin
                    if_pc_q    <= 32'h0;
                    if_instr_q <= NOP_INSTR;
                    if_valid_q <= 1'b0;
                    if (redirect_i) pc_q <= redirect_pc_i;
                    state_q <= RUN;
                end
                RUN: begin
                    if (redirect_i) begin
                        pc_q       <= redirect_pc_i;
                        wrap_q     <= 1'b0;
                        if_pc_q    <= 32'h0;
                        if_instr_q <= NOP_INSTR;
                        if_valid_q <= 1'b0;
                    end else if (!stall_i) begin
                        if (legal) begin
                            if_pc_q    <= pc_q;
                            if_instr_q <= imem_instr_i;
                            if_valid_q <= 1'b1;
                            pc_q       <= pc_inc[31:0];
                            wrap_q     <= pc_inc[32];
                            cnt_q      <= cnt_q + 32'd1;
                        end else begin
                            if_pc_q    <= 32'h0;
                            if_instr_q <= NOP_INSTR;
                            if_valid_q <= 1'b0;
                            state_q    <= HALT;
                        end
                    end
                end
                default: begin
                    if_pc_q    <= 32'h0;
                    if_instr_q <= NOP_INSTR;
                    if_valid_q <= 1'b0;
                    if (redirect_i) begin
                        pc_q    <= redirect_pc_i;
                        wrap_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
            endcase
        end
    end

    assign imem_pc_o     = pc_q;
    assign if_id_pc_o    = if_pc_q;
    assign if_id_instr_o = if_instr_q;
    assign if_id_valid_o = if_valid_q;
    assign halted_o      = (state_q == HALT);
    assign fetch_count_o = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect traffic,
// every cycle compared against a transaction-level reference model.
module tb_fetch_stage;
    localparam int unsigned IMEM_BYTES = 36;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_pc, imem_instr, if_id_pc, if_id_instr, fetch_count;
    logic        if_id_valid, halted;

    logic [31:0] mem [9];

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM_BYTES), .NOP_INSTR(NOP)) dut (
        .clk_i(clk), .reset_i(reset), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_pc_o(imem_pc), .imem_instr_i(imem_instr),
        .if_id_pc_o(if_id_pc), .if_id_instr_o(if_id_instr), .if_id_valid_o(if_id_valid),
        .halted_o(halted), .fetch_count_o(fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_instr = ((imem_pc >> 2) < 32'd9) ? mem[imem_pc[5:2]] : 32'hDEAD_BEEF;

    // Reference model: program state as plain integers.
    longint unsigned m_pc;
    int              m_mode;   // 0 boot, 1 running, 2 halted
    logic [31:0]     m_ipc, m_ins, m_cnt;
    logic            m_v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 0; m_mode = 0; m_ipc = 0; m_ins = NOP; m_v = 0; m_cnt = 0;
    endtask

    task automatic m_bubble();
        m_ipc = 0; m_ins = NOP; m_v = 0;
    endtask

    task automatic m_step(input logic st, input logic rd, input logic [31:0] rpc);
        bit fetch_ok;
        fetch_ok = (m_pc % 4 == 0) && (m_pc + 4 <= IMEM_BYTES);
        if (m_mode == 0) begin
            m_bubble();
            if (rd) m_pc = rpc;
            m_mode = 1;
        end else if (m_mode == 2) begin
            m_bubble();
            if (rd) begin m_pc = rpc; m_mode = 1; end
        end else if (rd) begin
            m_bubble();
            m_pc = rpc;
        end else if (!st) begin
            if (fetch_ok) begin
                m_ipc = m_pc[31:0];
                m_ins = mem[m_pc / 4];
                m_v   = 1;
                m_pc  = m_pc + 4;
                m_cnt = m_cnt + 1;
            end else begin
                m_bubble();
                m_mode = 2;
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".imem_pc"},  imem_pc,            m_pc[31:0]);
        chk({ph, ".ifid_pc"},  if_id_pc,           m_ipc);
        chk({ph, ".ifid_ins"}, if_id_instr,        m_ins);
        chk({ph, ".ifid_v"},   {31'h0, if_id_valid}, {31'h0, m_v});
        chk({ph, ".halted"},   {31'h0, halted},    {31'h0, (m_mode == 2)});
        chk({ph, ".count"},    fetch_count,        m_cnt);
    endtask

    // Drive one cycle's inputs, step the model on the edge, compare at the falling edge.
    task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc, input string ph);
        stall = st; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        m_step(st, rd, rpc);
        @(negedge clk);
        check_all(ph);
    endtask

    initial begin
        logic [31:0] tgt;
        for (int i = 0; i < 9; i++) mem[i] = $urandom;
        mem[0] = 32'h0001_1020; mem[1] = 32'h0085_3022;
        mem[2] = 32'h0109_5024; mem[6] = 32'hFE81_707A;

        m_reset();
        #12;
        check_all("reset");
        @(negedge clk); reset = 1'b0;

        cyc(0, 0, 0, "boot");
        chk("boot.valid0", {31'h0, if_id_valid}, 32'h0);
        cyc(0, 0, 0, "f0");
        chk("f0.instr", if_id_instr, 32'h0001_1020);
        cyc(0, 0, 0, "f4");
        chk("f4.count", fetch_count, 32'd2);

        for (int i = 0; i < 3; i++) cyc(1, 0, 0, "stall");
        chk("stall.imem_pc", imem_pc, 32'h8);
        chk("stall.ifid_pc", if_id_pc, 32'h4);
        cyc(0, 0, 0, "unstall");
        chk("unstall.instr", if_id_instr, 32'h0109_5024);

        cyc(1, 1, 32'h18, "redir_stall");
        chk("redir.imem_pc", imem_pc, 32'h18);
        cyc(0, 0, 0, "redir_tgt");
        chk("redir.instr", if_id_instr, 32'hFE81_707A);

        cyc(0, 0, 0, "seq1c");
        cyc(0, 0, 0, "seq20");
        chk("end.last_pc", if_id_pc, 32'h20);
        cyc(0, 0, 0, "end");
        chk("end.halted", {31'h0, halted}, 32'h1);
        cyc(1, 0, 0, "halt_hold");
        chk("end.imem_pc", imem_pc, 32'h24);

        cyc(0, 1, 32'h6, "mis_redir");
        cyc(0, 0, 0, "mis_halt");
        chk("mis.halted", {31'h0, halted}, 32'h1);
        cyc(0, 1, 32'h4, "mis_exit");
        chk("mis.exit", {31'h0, halted}, 32'h0);
        cyc(0, 0, 0, "mis_f4");
        chk("mis.instr", if_id_instr, 32'h0085_3022);

        for (int i = 0; i < 400; i++) begin
            tgt = 32'($urandom_range(0, 11)) * 4;
            if ($urandom_range(0, 4) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), tgt, "rand");
        end

        cyc(0, 1, 32'h8, "pre_rst");
        cyc(0, 0, 0, "pre_rst8");
        cyc(0, 0, 0, "pre_rstc");
        chk("pre_rst.pc", imem_pc, 32'h10);
        #2 reset = 1'b1;
        #1;
        m_reset();
        check_all("async_rst");
        chk("async_rst.instr", if_id_instr, NOP);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
